// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: W-bit add / two's-complement subtract computed on one
// N-bit ripple-carry slice over K = W/N cycles, least-significant chunk first.
// Operands arrive and results leave through valid/ready handshakes.

// Nbit_adder: plain N-bit ripple-carry adder slice with carry in and out.
module Nbit_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  logic carry;

  // Ripple the carry from bit 0 upward, one full adder per bit.
  always_comb begin
    carry = c_in;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    c_out = carry;
  end

endmodule

module addsub_seq_ctrl #(
  parameter int W = 24,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out
);

  localparam int K  = W / N;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           op_q, op_d;
  logic           cy_q, cy_d;
  logic [CW-1:0]  k_q, k_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           c_out_q, c_out_d;

  logic [N-1:0]   a_chunk;
  logic [N-1:0]   b_chunk;
  logic [N-1:0]   slice_sum;
  logic           slice_cout;

  // The single shared adder slice; subtract inverts b and relies on cy starting at 1.
  Nbit_adder #(.N(N)) u_slice (
    .a     (a_chunk),
    .b     (b_chunk ^ {N{op_q}}),
    .c_in  (cy_q),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  // Select the operand chunk addressed by the chunk counter.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < K; i++) begin
      if (k_q == CW'(i)) begin
        a_chunk = a_q[i*N +: N];
        b_chunk = b_q[i*N +: N];
      end
    end
  end

  // Next-state and datapath update: accept in IDLE, one chunk per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cy_d    = cy_q;
    k_d     = k_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cy_d    = op;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < K; i++) begin
          if (k_q == CW'(i)) begin
            sum_d[i*N +: N] = slice_sum;
          end
        end
        cy_d = slice_cout;
        if (k_q == CW'(K - 1)) begin
          c_out_d = slice_cout;
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset overrides any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      cy_q    <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cy_q    <= cy_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  // Handshake flags come straight from the state; results from their registers.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = sum_q;
    c_out     = c_out_q;
  end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Testbench for addsub_seq_ctrl: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_addsub_seq_ctrl;

  localparam int W = 24;
  localparam int N = 8;
  localparam int K = W / N;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;

  int checkCount;
  int errorCount;

  addsub_seq_ctrl #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Result of the whole operation as one wide number: {c_out, sum}.
  function automatic logic [W:0] refModel(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic sub);
    logic [W:0] addend;
    addend = sub ? {1'b0, ~y} : {1'b0, y};
    return {1'b0, x} + addend + (W+1)'(sub);
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Drive junk on the operand inputs so we can see they are ignored mid-operation.
  task automatic scrambleInputs(input logic valid_level);
    a        = W'($urandom);
    b        = W'($urandom);
    op       = 1'($urandom);
    in_valid = valid_level;
  endtask

  // One full operation: present, accept, count latency, backpressure, take result.
  task automatic applyStimulus(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                               input logic op_sub, input int ready_gap);
    logic [W:0] expected;
    int         waited;
    int         lat;
    expected  = refModel(op_a, op_b, op_sub);
    a         = op_a;
    b         = op_b;
    op        = op_sub;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    waited    = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 50) begin
      scrambleInputs(1'($urandom));
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", 64'(lat), 64'(K));
    if (!out_valid) begin
      in_valid = 1'b0;
      return;
    end
    for (int g = 0; g < ready_gap; g++) begin
      scrambleInputs(1'b1);
      @(posedge clk); #1;
      checkOutput("hold_sum", 64'(sum), 64'(expected[W-1:0]));
      checkOutput("hold_cout", 64'(c_out), 64'(expected[W]));
      checkOutput("hold_flags", 64'({in_ready, out_valid}), 64'(2'b01));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("sum", 64'(sum), 64'(expected[W-1:0]));
    checkOutput("c_out", 64'(c_out), 64'(expected[W]));
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("idle_after", 64'({in_ready, out_valid}), 64'(2'b10));
  endtask

  // Main sequence: reset, directed cases, reset mid-RUN, randomized regression.
  initial begin
    checkCount = 0;
    errorCount = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 24'h0000AA;
    b         = 24'h000055;
    op        = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_flags", 64'({in_ready, out_valid}), 64'(2'b10));
    checkOutput("rst_sum", 64'(sum), 64'd0);
    checkOutput("rst_cout", 64'(c_out), 64'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_flags", 64'({in_ready, out_valid}), 64'(2'b10));

    applyStimulus(24'h00FFFF, 24'h000001, 1'b0, 0);
    applyStimulus(24'h000005, 24'h000007, 1'b1, 1);
    applyStimulus(24'h000007, 24'h000005, 1'b1, 0);
    applyStimulus(24'hFFFFFF, 24'h000001, 1'b0, 2);
    applyStimulus(24'h123456, 24'h123456, 1'b1, 0);
    applyStimulus(24'h0000FF, 24'h000001, 1'b0, 5);
    applyStimulus(24'hABCDEF, 24'h012345, 1'b0, 0);

    a        = 24'h111111;
    b        = 24'h222222;
    op       = 1'b0;
    in_valid = 1'b1;
    checkOutput("pre_abort_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("pre_abort_busy", 64'({in_ready, out_valid}), 64'(2'b00));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_flags", 64'({in_ready, out_valid}), 64'(2'b10));
    checkOutput("abort_sum", 64'(sum), 64'd0);
    checkOutput("abort_cout", 64'(c_out), 64'd0);
    applyStimulus(24'h000010, 24'h000020, 1'b0, 0);

    for (int n = 0; n < 1000; n++) begin
      int idle_gap;
      idle_gap = int'($urandom_range(0, 2));
      in_valid = 1'b0;
      for (int g = 0; g < idle_gap; g++) begin
        @(posedge clk); #1;
      end
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
